// File: rtl/fw_wishbone_sram_arb_amo.sv
// Two-port Wishbone front-end sharing one byte-enable SRAM.
// Round-robin arbitration, plain read/write and AMO ops.
module fw_wishbone_sram_arb_amo #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADR_WIDTH-1:0]   t0_adr,
  input  logic [DAT_WIDTH-1:0]   t0_dat_w,
  output logic [DAT_WIDTH-1:0]   t0_dat_r,
  input  logic                   t0_cyc,
  input  logic                   t0_stb,
  input  logic                   t0_we,
  input  logic [DAT_WIDTH/8-1:0] t0_sel,
  input  logic [3:0]             t0_tgc,
  output logic                   t0_ack,
  output logic                   t0_err,
  input  logic [ADR_WIDTH-1:0]   t1_adr,
  input  logic [DAT_WIDTH-1:0]   t1_dat_w,
  output logic [DAT_WIDTH-1:0]   t1_dat_r,
  input  logic                   t1_cyc,
  input  logic                   t1_stb,
  input  logic                   t1_we,
  input  logic [DAT_WIDTH/8-1:0] t1_sel,
  input  logic [3:0]             t1_tgc,
  output logic                   t1_ack,
  output logic                   t1_err,
  output logic [ADR_WIDTH-1:0]   i_addr,
  output logic                   i_read_en,
  output logic                   i_write_en,
  output logic [DAT_WIDTH/8-1:0] i_byte_en,
  output logic [DAT_WIDTH-1:0]   i_write_data,
  input  logic [DAT_WIDTH-1:0]   i_read_data
);

  localparam int SW = DAT_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, CMD, RDATA, AMOWR, ACK
  } state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic                 we_q, we_d;
  logic [3:0]           tgc_q, tgc_d;
  logic [DAT_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADR_WIDTH-1:0] addr_d;
  logic                 rd_en_d, wr_en_d;
  logic [SW-1:0]        be_d;
  logic [DAT_WIDTH-1:0] wdata_d;
  logic                 ack0_d, ack1_d;
  logic [DAT_WIDTH-1:0] dat_r0_d, dat_r1_d;

  logic                 req0, req1, pick;
  logic [ADR_WIDTH-1:0] m_adr;
  logic [DAT_WIDTH-1:0] m_dat;
  logic                 m_we;
  logic [SW-1:0]        m_sel;
  logic [3:0]           m_tgc;
  logic                 go_ack;
  logic [DAT_WIDTH-1:0] ack_data;
  logic [DAT_WIDTH-1:0] amo_new;

  function automatic logic is_amo(input logic [3:0] tgc);
    return (tgc >= 4'd1) && (tgc <= 4'd5);
  endfunction

  assign t0_err = 1'b0;
  assign t1_err = 1'b0;

  assign req0 = t0_cyc & t0_stb;
  assign req1 = t1_cyc & t1_stb;
  // On a tie the port that did not win last time goes first
  assign pick  = (req0 & req1) ? ~last_q : req1;
  assign m_adr = pick ? t1_adr   : t0_adr;
  assign m_dat = pick ? t1_dat_w : t0_dat_w;
  assign m_we  = pick ? t1_we    : t0_we;
  assign m_sel = pick ? t1_sel   : t0_sel;
  assign m_tgc = pick ? t1_tgc   : t0_tgc;

  always_comb begin
    amo_new = i_read_data;
    unique case (1'b1)
      (tgc_q == 4'd1): amo_new = dat_q;
      (tgc_q == 4'd2): amo_new = i_read_data + dat_q;
      (tgc_q == 4'd3): amo_new = i_read_data & dat_q;
      (tgc_q == 4'd4): amo_new = i_read_data | dat_q;
      (tgc_q == 4'd5): amo_new = i_read_data ^ dat_q;
      default:         amo_new = i_read_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    dat_d    = dat_q;
    we_d     = we_q;
    tgc_d    = tgc_q;
    rdata_d  = rdata_q;
    addr_d   = i_addr;
    be_d     = i_byte_en;
    wdata_d  = i_write_data;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    dat_r0_d = t0_dat_r;
    dat_r1_d = t1_dat_r;
    go_ack   = 1'b0;
    ack_data = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = pick;
          dat_d   = m_dat;
          we_d    = m_we;
          tgc_d   = m_tgc;
          addr_d  = m_adr;
          be_d    = m_sel;
          if (!is_amo(m_tgc) && m_we) begin
            wr_en_d = 1'b1;
            wdata_d = m_dat;
          end else begin
            rd_en_d = 1'b1;
          end
          state_d = CMD;
        end
      end
      CMD: begin
        if (!is_amo(tgc_q) && we_q) go_ack = 1'b1;
        else state_d = RDATA;
      end
      RDATA: begin
        rdata_d = i_read_data;
        if (is_amo(tgc_q)) begin
          wr_en_d = 1'b1;
          wdata_d = amo_new;
          state_d = AMOWR;
        end else begin
          go_ack   = 1'b1;
          ack_data = i_read_data;
        end
      end
      AMOWR: go_ack = 1'b1;
      ACK: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ack only if the initiator is still waiting for it
    if (go_ack) begin
      state_d = ACK;
      if (grant_q) begin
        ack1_d   = req1;
        dat_r1_d = ack_data;
      end else begin
        ack0_d   = req0;
        dat_r0_d = ack_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      dat_q        <= '0;
      we_q         <= 1'b0;
      tgc_q        <= '0;
      rdata_q      <= '0;
      i_addr       <= '0;
      i_read_en    <= 1'b0;
      i_write_en   <= 1'b0;
      i_byte_en    <= '0;
      i_write_data <= '0;
      t0_ack       <= 1'b0;
      t1_ack       <= 1'b0;
      t0_dat_r     <= '0;
      t1_dat_r     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      tgc_q        <= tgc_d;
      rdata_q      <= rdata_d;
      i_addr       <= addr_d;
      i_read_en    <= rd_en_d;
      i_write_en   <= wr_en_d;
      i_byte_en    <= be_d;
      i_write_data <= wdata_d;
      t0_ack       <= ack0_d;
      t1_ack       <= ack1_d;
      t0_dat_r     <= dat_r0_d;
      t1_dat_r     <= dat_r1_d;
    end
  end

endmodule

// File: tb/tb_fw_wishbone_sram_arb_amo.sv
// Bench for fw_wishbone_sram_arb_amo: SRAM model, word-level
// reference memory, arbitration model and latency checks.
module tb_fw_wishbone_sram_arb_amo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] t0_adr, t0_dat_w, t0_dat_r;
  logic        t0_cyc, t0_stb, t0_we, t0_ack, t0_err;
  logic [3:0]  t0_sel, t0_tgc;
  logic [31:0] t1_adr, t1_dat_w, t1_dat_r;
  logic        t1_cyc, t1_stb, t1_we, t1_ack, t1_err;
  logic [3:0]  t1_sel, t1_tgc;
  logic [31:0] i_addr, i_write_data, i_read_data;
  logic        i_read_en, i_write_en;
  logic [3:0]  i_byte_en;

  fw_wishbone_sram_arb_amo dut (
    .clock(clock), .reset_n(reset_n),
    .t0_adr(t0_adr), .t0_dat_w(t0_dat_w), .t0_dat_r(t0_dat_r),
    .t0_cyc(t0_cyc), .t0_stb(t0_stb), .t0_we(t0_we),
    .t0_sel(t0_sel), .t0_tgc(t0_tgc),
    .t0_ack(t0_ack), .t0_err(t0_err),
    .t1_adr(t1_adr), .t1_dat_w(t1_dat_w), .t1_dat_r(t1_dat_r),
    .t1_cyc(t1_cyc), .t1_stb(t1_stb), .t1_we(t1_we),
    .t1_sel(t1_sel), .t1_tgc(t1_tgc),
    .t1_ack(t1_ack), .t1_err(t1_err),
    .i_addr(i_addr), .i_read_en(i_read_en),
    .i_write_en(i_write_en), .i_byte_en(i_byte_en),
    .i_write_data(i_write_data), .i_read_data(i_read_data)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  logic [31:0] sram [64];
  logic [31:0] ref_mem [64];
  int mlast;
  int wr_cnt = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;

  always @(posedge clock) begin
    if (i_write_en) begin
      for (int b = 0; b < 4; b++)
        if (i_byte_en[b])
          sram[i_addr[5:0]][b*8 +: 8] <= i_write_data[b*8 +: 8];
    end
    if (i_read_en) i_read_data <= sram[i_addr[5:0]];
    if (reset_n && i_write_en) wr_cnt <= wr_cnt + 1;
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (t0_ack) ack0_cnt++;
      if (t1_ack) ack1_cnt++;
      check("ack_excl", {31'b0, t0_ack & t1_ack}, 0);
      check("strb_excl", {31'b0, i_read_en & i_write_en}, 0);
      check("err_zero", {31'b0, t0_err | t1_err}, 0);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic ref_apply(input logic [31:0] a, d, input logic w,
                           input logic [3:0] s, g,
                           output logic [31:0] old);
    logic [31:0] nv;
    old = ref_mem[a[5:0]];
    case (g)
      4'd1: nv = d;
      4'd2: nv = old + d;
      4'd3: nv = old & d;
      4'd4: nv = old | d;
      4'd5: nv = old ^ d;
      default: nv = d;
    endcase
    if ((g >= 1 && g <= 5) || w)
      ref_mem[a[5:0]] = merge(old, nv, s);
  endtask

  task automatic drive(input int p, input logic on,
                       input logic [31:0] a, d, input logic w,
                       input logic [3:0] s, g);
    if (p == 0) begin
      t0_cyc = on; t0_stb = on; t0_adr = a; t0_dat_w = d;
      t0_we = w; t0_sel = s; t0_tgc = g;
    end else begin
      t1_cyc = on; t1_stb = on; t1_adr = a; t1_dat_w = d;
      t1_we = w; t1_sel = s; t1_tgc = g;
    end
  endtask

  task automatic single(input int p, input logic [31:0] a, d,
                        input logic w, input logic [3:0] s, g,
                        output logic [31:0] r);
    int n = 0;
    int wb = wr_cnt;
    int ob = (p == 0) ? ack1_cnt : ack0_cnt;
    int ob2;
    logic [31:0] e;
    logic amo = (g >= 1 && g <= 5);
    logic got = 0;
    r = '0;
    ref_apply(a, d, w, s, g, e);
    drive(p, 1, a, d, w, s, g);
    while (!got && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (p == 0 ? t0_ack : t1_ack) begin
        got = 1;
        r = (p == 0) ? t0_dat_r : t1_dat_r;
      end
    end
    drive(p, 0, 0, 0, 0, 0, 0);
    check("ack_seen", {31'b0, got}, 1);
    check("latency", n, amo ? 4 : (w ? 2 : 3));
    if (amo || !w) check("dat_r", r, e);
    check("wr_pulses", wr_cnt - wb, (amo || w) ? 1 : 0);
    mlast = p;
    @(posedge clock); #1;
    ob2 = (p == 0) ? ack1_cnt : ack0_cnt;
    check("other_ack", ob2 - ob, 0);
    @(negedge clock);
  endtask

  task automatic dual(input logic [31:0] a0, d0, input logic w0,
                      input logic [3:0] s0, g0,
                      input logic [31:0] a1, d1, input logic w1,
                      input logic [3:0] s1, g1,
                      output logic [31:0] r0, r1);
    int exp_first = (mlast == 1) ? 0 : 1;
    int first = -1;
    int n = 0;
    logic got0 = 0, got1 = 0;
    logic [31:0] e0, e1;
    r0 = '0; r1 = '0;
    if (exp_first == 0) begin
      ref_apply(a0, d0, w0, s0, g0, e0);
      ref_apply(a1, d1, w1, s1, g1, e1);
    end else begin
      ref_apply(a1, d1, w1, s1, g1, e1);
      ref_apply(a0, d0, w0, s0, g0, e0);
    end
    drive(0, 1, a0, d0, w0, s0, g0);
    drive(1, 1, a1, d1, w1, s1, g1);
    while (!(got0 && got1) && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (t0_ack && !got0) begin
        got0 = 1; r0 = t0_dat_r;
        drive(0, 0, 0, 0, 0, 0, 0);
        if (first < 0) first = 0;
      end
      if (t1_ack && !got1) begin
        got1 = 1; r1 = t1_dat_r;
        drive(1, 0, 0, 0, 0, 0, 0);
        if (first < 0) first = 1;
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("dual_acks", {30'b0, got0, got1}, 3);
    check("dual_first", first, exp_first);
    if ((g0 >= 1 && g0 <= 5) || !w0) check("dual_r0", r0, e0);
    if ((g1 >= 1 && g1 <= 5) || !w1) check("dual_r1", r1, e1);
    mlast = 1 - exp_first;
    @(posedge clock); #1;
    @(negedge clock);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_acks"}, {30'b0, t0_ack, t1_ack}, 0);
    check({tag, "_dat_r0"}, t0_dat_r, 0);
    check({tag, "_dat_r1"}, t1_dat_r, 0);
    check({tag, "_strb"}, {30'b0, i_read_en, i_write_en}, 0);
    check({tag, "_addr"}, i_addr, 0);
    check({tag, "_wdata"}, i_write_data, 0);
    check({tag, "_be"}, {28'b0, i_byte_en}, 0);
  endtask

  initial begin
    logic [31:0] r, r0, r1, e;
    int p, p2;
    for (int i = 0; i < 64; i++) begin
      sram[i]    = (i * 32'h01010101) ^ 32'hA5A5A5A5;
      ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A5A5A5;
    end
    i_read_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    mlast = 1;
    repeat (3) @(posedge clock);
    #1 check_reset_outs("rst");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    dual(32'h10, 0, 0, 4'hF, 0, 32'h11, 0, 0, 4'hF, 0, r0, r1);
    dual(32'h12, 0, 0, 4'hF, 0, 32'h13, 0, 0, 4'hF, 0, r0, r1);

    single(0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 0, r);
    single(0, 32'h10, 0, 0, 4'hF, 0, r);
    check("tp_rd_beef", r, 32'hDEADBEEF);

    single(0, 32'h20, 32'h11223344, 1, 4'hF, 0, r);
    single(0, 32'h20, 32'h0000AA00, 1, 4'h2, 0, r);
    single(0, 32'h20, 0, 0, 4'hF, 0, r);
    check("tp_byte_wr", r, 32'h1122AA44);

    single(1, 32'h30, 32'hFFFFFFFF, 1, 4'hF, 0, r);
    single(1, 32'h30, 32'h1, 0, 4'hF, 4'd2, r);
    check("tp_add_old", r, 32'hFFFFFFFF);
    single(1, 32'h30, 0, 0, 4'hF, 0, r);
    check("tp_add_wrap", r, 32'h0);

    single(0, 32'h10, 0, 0, 4'hF, 0, r);
    dual(32'h10, 0, 0, 4'hF, 0,
         32'h20, 32'hCAFEF00D, 0, 4'hF, 4'd1, r0, r1);
    check("tp_swap_old", r1, 32'h1122AA44);
    single(0, 32'h20, 0, 0, 4'hF, 0, r);
    check("tp_swap_new", r, 32'hCAFEF00D);

    drive(0, 1, 32'h30, 32'h5, 0, 4'hF, 4'd2);
    repeat (3) @(posedge clock);
    #1 check("amowr_we", {31'b0, i_write_en}, 1);
    reset_n = 1'b0;
    #1 check_reset_outs("midrst");
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    mlast = 1;
    @(negedge clock);
    dual(32'h30, 0, 0, 4'hF, 0, 32'h31, 0, 0, 4'hF, 0, r0, r1);
    check("rst_no_write", r0, 32'h0);

    p = ack1_cnt;
    p2 = wr_cnt;
    drive(1, 1, 32'h08, 32'hFFFF0000, 0, 4'hF, 4'd5);
    @(posedge clock); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (6) @(posedge clock);
    #1 check("drop_no_ack", ack1_cnt - p, 0);
    check("drop_amo_wr", wr_cnt - p2, 1);
    ref_apply(32'h08, 32'hFFFF0000, 0, 4'hF, 4'd5, e);
    mlast = 1;
    @(negedge clock);
    single(1, 32'h08, 0, 0, 4'hF, 0, r);

    for (int i = 0; i < 40; i++)
      single($urandom_range(0, 1), $urandom_range(0, 15), $urandom,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 7)), r);
    for (int i = 0; i < 15; i++)
      dual($urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
           $urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
           r0, r1);
    for (int i = 0; i < 16; i++)
      single(0, i, 0, 0, 4'hF, 0, r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
